// File: rtl/acc_exec_if.sv
// Instruction, branch, memory and architectural-state signals of the accumulator execution unit.
interface acc_exec_if #(
    parameter int unsigned W    = 8,
    parameter int unsigned NREG = 8
);
    localparam int unsigned RW = $clog2(NREG);

    logic          in_valid;
    logic          in_ready;
    logic [3:0]    in_op;
    logic [RW-1:0] in_reg;
    logic          done;
    logic          br_taken;
    logic [W-1:0]  br_target;
    logic          mem_req;
    logic          mem_we;
    logic [W-1:0]  mem_addr;
    logic [W-1:0]  mem_wdata;
    logic [W-1:0]  mem_rdata;
    logic          mem_ack;
    logic [W-1:0]  acc_out;
    logic          carry_out;
    logic          ovf_out;
    logic          zero_out;
    logic          halted;

    modport master (
        output in_valid, in_op, in_reg, mem_rdata, mem_ack,
        input  in_ready, done, br_taken, br_target, mem_req, mem_we, mem_addr, mem_wdata,
        input  acc_out, carry_out, ovf_out, zero_out, halted
    );

    modport slave (
        input  in_valid, in_op, in_reg, mem_rdata, mem_ack,
        output in_ready, done, br_taken, br_target, mem_req, mem_we, mem_addr, mem_wdata,
        output acc_out, carry_out, ovf_out, zero_out, halted
    );
endinterface

// File: rtl/acc_exec_unit.sv
// Single-issue accumulator execution unit: register file, ALU with carry/overflow flags,
// branch evaluation and a blocking load/store port.
module acc_exec_unit #(
    parameter int unsigned W    = 8,
    parameter int unsigned NREG = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    acc_exec_if.slave  bus
);
    typedef enum logic [1:0] {StIdle, StMem, StHalted} state_e;

    localparam logic [3:0] OpPull  = 4'h0;
    localparam logic [3:0] OpIncr  = 4'h1;
    localparam logic [3:0] OpPush  = 4'h2;
    localparam logic [3:0] OpMatch = 4'h3;
    localparam logic [3:0] OpLdr   = 4'h4;
    localparam logic [3:0] OpStor  = 4'h5;
    localparam logic [3:0] OpSuba  = 4'h6;
    localparam logic [3:0] OpSub   = 4'h7;
    localparam logic [3:0] OpBne   = 4'h8;
    localparam logic [3:0] OpClr   = 4'h9;
    localparam logic [3:0] OpMin   = 4'hA;
    localparam logic [3:0] OpBeq   = 4'hB;
    localparam logic [3:0] OpAddo  = 4'hC;
    localparam logic [3:0] OpAddi  = 4'hD;
    localparam logic [3:0] OpAddz  = 4'hE;
    localparam logic [3:0] OpHalt  = 4'hF;

    state_e       state_q;
    logic [W-1:0] acc_q;
    logic         c_q, v_q;
    logic [W-1:0] rf_q [NREG];
    logic         done_q, br_taken_q;
    logic [W-1:0] br_target_q;
    logic         mem_req_q, mem_we_q;
    logic [W-1:0] mem_addr_q, mem_wdata_q;

    logic [W-1:0] opnd;
    logic [W-1:0] acc_d;
    logic         c_d, v_d;
    logic         rf_we;
    logic [W-1:0] rf_wdata;
    logic         br_taken_d;
    logic [W:0]   sum, diff;

    assign opnd = rf_q[bus.in_reg];

    always_comb begin
        acc_d      = acc_q;
        c_d        = c_q;
        v_d        = v_q;
        rf_we      = 1'b0;
        rf_wdata   = acc_q;
        br_taken_d = 1'b0;
        sum        = '0;
        // diff[W] is the borrow out of ACC - R[r]
        diff       = {1'b0, acc_q} - {1'b0, opnd};
        case (bus.in_op)
            OpPull:  rf_we = 1'b1;
            OpIncr: begin
                sum          = {1'b0, acc_q} + (W+1)'(1);
                {c_d, acc_d} = sum;
            end
            OpPush:  acc_d = opnd;
            OpMatch: acc_d = {{(W-1){1'b0}}, acc_q == opnd};
            OpSuba:  acc_d = diff[W] ? (opnd - acc_q) : diff[W-1:0];
            OpSub: begin
                acc_d = diff[W-1:0];
                c_d   = ~diff[W];
            end
            OpBne:   br_taken_d = (acc_q != '0);
            OpClr: begin
                rf_we    = 1'b1;
                rf_wdata = '0;
            end
            OpMin: begin
                acc_d = diff[W-1:0];
                v_d   = (acc_q[W-1] != opnd[W-1]) && (diff[W-1] != acc_q[W-1]);
            end
            OpBeq:   br_taken_d = (acc_q == '0);
            OpAddo: begin
                sum          = {1'b0, acc_q} + {1'b0, opnd};
                {c_d, acc_d} = sum;
            end
            OpAddi: begin
                sum          = {1'b0, acc_q} + {1'b0, opnd} + (W+1)'(c_q);
                {c_d, acc_d} = sum;
            end
            OpAddz: begin
                sum          = {1'b0, acc_q} + (W+1)'(c_q);
                {c_d, acc_d} = sum;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            acc_q       <= '0;
            c_q         <= 1'b0;
            v_q         <= 1'b0;
            done_q      <= 1'b0;
            br_taken_q  <= 1'b0;
            br_target_q <= '0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            for (int i = 0; i < NREG; i++) rf_q[i] <= '0;
        end else begin
            done_q     <= 1'b0;
            br_taken_q <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (bus.in_valid) begin
                        br_target_q <= opnd;
                        case (bus.in_op)
                            OpLdr, OpStor: begin
                                state_q     <= StMem;
                                mem_req_q   <= 1'b1;
                                mem_we_q    <= (bus.in_op == OpStor);
                                mem_addr_q  <= opnd;
                                mem_wdata_q <= acc_q;
                            end
                            OpHalt: begin
                                state_q <= StHalted;
                                done_q  <= 1'b1;
                            end
                            default: begin
                                acc_q      <= acc_d;
                                c_q        <= c_d;
                                v_q        <= v_d;
                                br_taken_q <= br_taken_d;
                                done_q     <= 1'b1;
                                if (rf_we) rf_q[bus.in_reg] <= rf_wdata;
                            end
                        endcase
                    end
                end
                StMem: begin
                    if (bus.mem_ack) begin
                        if (!mem_we_q) acc_q <= bus.mem_rdata;
                        mem_req_q <= 1'b0;
                        done_q    <= 1'b1;
                        state_q   <= StIdle;
                    end
                end
                StHalted: ;
                default: state_q <= StIdle;
            endcase
        end
    end

    assign bus.in_ready  = (state_q == StIdle);
    assign bus.done      = done_q;
    assign bus.br_taken  = br_taken_q;
    assign bus.br_target = br_target_q;
    assign bus.mem_req   = mem_req_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.acc_out   = acc_q;
    assign bus.carry_out = c_q;
    assign bus.ovf_out   = v_q;
    assign bus.zero_out  = (acc_q == '0);
    assign bus.halted    = (state_q == StHalted);
endmodule
